coin_sched: RTL and testbench
=============================

COIN_SCHED -- requirements
Module: coin_sched

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, meaning coin spawn x (left edge).
REQ-002 SHALL have parameter COIN_WIDTH, default 20, meaning X_Coin_R minus X_Coin_L.
REQ-003 SHALL have parameter SPEED, default 2, meaning pixels moved per tick.
REQ-004 SHALL have parameter RESPAWN_TICKS, default 60, meaning ticks hidden before the next spawn.
REQ-005 SHALL have parameters Y_MIN, default 40, and Y_MAX, default 400, meaning the legal coin-top y range.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports Start and Ack, inputs, 1 bit each: game start pulse; game-over acknowledge pulse.
REQ-009 SHALL have port tick, input, 1 bit: one-cycle frame-advance pulse.
REQ-010 SHALL have port hit, input, 1 bit: registered bird/coin overlap level from the collision block.
REQ-011 SHALL have port Rand, input, 10 bits: free-running pseudo-random value.
REQ-012 SHALL have ports X_Coin_L, X_Coin_R and Y_Coin, outputs, 10 bits each: coin left edge, right edge and top edge.
REQ-013 SHALL have ports coin_visible and score_inc, outputs, 1 bit each: coin drawn/collidable; one-cycle collect pulse.
REQ-014 SHALL have port coin_count, output, 8 bits: coins collected this game.
REQ-015 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-016 SHALL implement FSM states IDLE, SPAWN, MOVE, COLLECT and WAIT.
REQ-017 IDLE SHALL hold the coin hidden; on Start, coin_count SHALL clear to 0 and the FSM SHALL enter SPAWN next cycle.
REQ-018 SPAWN SHALL last one cycle, load X_Coin_L=SCREEN_W, load Y_Coin=clamp(Rand[8:0], Y_MIN, Y_MAX), then enter MOVE.
REQ-019 MOVE SHALL reduce X_Coin_L by SPEED on each tick; if X_Coin_L < SPEED at that tick, the coin is missed: no move, enter WAIT.
REQ-020 X_Coin_R SHALL be X_Coin_L+COIN_WIDTH combinationally, and no subtraction SHALL wrap below 0.
REQ-021 In MOVE, hit=1 SHALL enter COLLECT; if hit and tick arrive together, COLLECT wins and the coin does not move.
REQ-022 COLLECT SHALL last one cycle: score_inc=1, coin_count+1 saturating at 255, then enter WAIT.
REQ-023 WAIT SHALL count RESPAWN_TICKS ticks (counter cleared on entry), then enter SPAWN; hit SHALL be ignored in WAIT.
REQ-024 coin_visible SHALL be 1 only in MOVE.
REQ-025 Ack in any non-IDLE state SHALL force IDLE next cycle, overriding hit, tick and counter expiry; coin_count SHALL hold its value.
REQ-026 Start outside IDLE SHALL be ignored.
REQ-027 score_inc SHALL pulse exactly once per collected coin; a hit level held high SHALL NOT produce a second pulse.

Reset
REQ-028 While reset=0, the block SHALL be in IDLE with X_Coin_L=SCREEN_W, Y_Coin=Y_MIN, coin_count=0, score_inc=0, coin_visible=0 and the WAIT counter at 0.
REQ-029 Reset asserted mid-MOVE or mid-WAIT SHALL abort immediately; nothing SHALL resume after release until Start.

Configuration
REQ-030 With COIN_SCHED_SPEEDUP_EN defined, the effective speed SHALL be SPEED+min(coin_count>>3, 2), with the miss test in REQ-019 using the effective speed.
REQ-031 Without COIN_SCHED_SPEEDUP_EN, the effective speed SHALL be constant SPEED and no speed-up logic SHALL be synthesised.

Structure
REQ-032 The shared package flappy_pkg SHALL hold the FSM state enum, the SCREEN_W, COIN_WIDTH and COIN_HEIGHT constants, and the 10-bit coordinate typedef.
REQ-033 The respawn counter SHALL be the sub-module coin_respawn_timer (inputs clear and tick; output done), with the FSM in the top level.

Verification
REQ-034 Reset, Start, then 1 cycle SHALL give SPAWN; with Rand=10 it SHALL give Y_Coin=40, and with Rand=500 it SHALL give Y_Coin=400 (500 mod 512 clamped).
REQ-035 In MOVE, 5 ticks from 640 SHALL give X_Coin_L=630 and X_Coin_R=650.
REQ-036 Holding hit=1 for 10 cycles in MOVE SHALL give exactly one score_inc pulse, coin_count=1, then WAIT with coin_visible=0.
REQ-037 Starting from X_Coin_L=1 with SPEED=2, one tick SHALL give WAIT with no wrap and coin_count unchanged; after 60 ticks it SHALL give SPAWN.
REQ-038 Ack together with hit in MOVE SHALL give IDLE next cycle, no score_inc, and coin_count held.
REQ-039 With COIN_SCHED_SPEEDUP_EN and coin_count=8, one tick SHALL move 3 px; with coin_count=255 plus another collect, the count SHALL stay 255 and the move SHALL be 4 px.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared flappy-game types and geometry constants: FSM state encoding,
// default screen/coin sizes and the 10-bit pixel coordinate type.
package flappy_pkg;

  localparam int SCREEN_W    = 640;
  localparam int COIN_WIDTH  = 20;
  localparam int COIN_HEIGHT = 20;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPAWN   = 3'd1,
    MOVE    = 3'd2,
    COLLECT = 3'd3,
    WAIT    = 3'd4
  } state_e;

endpackage

// File: rtl/coin_respawn_timer.sv
// Counts frame ticks while the coin is hidden; done fires combinationally on
// the tick that completes RESPAWN_TICKS, and clear holds the count at zero.
module coin_respawn_timer #(
  parameter int RESPAWN_TICKS = 60
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int CW = $clog2(RESPAWN_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = !clear && tick && (cnt_q == CW'(RESPAWN_TICKS - 1));
    cnt_d = cnt_q;
    if (clear || done) cnt_d = '0;
    else if (tick)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/coin_sched.sv
// Coin lifecycle scheduler: spawn at the right edge, scroll left per tick, collect or miss, respawn.
// Optional COIN_SCHED_SPEEDUP_EN raises scroll speed with the number of coins collected.
module coin_sched #(
  parameter int SCREEN_W      = flappy_pkg::SCREEN_W,
  parameter int COIN_WIDTH    = flappy_pkg::COIN_WIDTH,
  parameter int SPEED         = 2,
  parameter int RESPAWN_TICKS = 60,
  parameter int Y_MIN         = 40,
  parameter int Y_MAX         = 400
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       tick,
  input  logic       hit,
  input  logic [9:0] Rand,
  output logic [9:0] X_Coin_L,
  output logic [9:0] X_Coin_R,
  output logic [9:0] Y_Coin,
  output logic       coin_visible,
  output logic       score_inc,
  output logic [7:0] coin_count,
  output logic [2:0] state
);
  import flappy_pkg::*;

  state_e     state_q, state_d;
  coord_t     x_q, x_d, y_q, y_d;
  logic [7:0] count_q, count_d;
  logic       score_inc_q, visible_q;
  logic       tmr_done;
  coord_t     eff_speed;
  logic       rand_unused;

  assign rand_unused = Rand[9];

  function automatic coord_t clamp_y(input logic [8:0] r);
    coord_t y;
    if (int'(r) < Y_MIN)      y = coord_t'(Y_MIN);
    else if (int'(r) > Y_MAX) y = coord_t'(Y_MAX);
    else                      y = coord_t'(r);
    return y;
  endfunction

`ifdef COIN_SCHED_SPEEDUP_EN
  logic [4:0] speed_grp;
  assign speed_grp = count_q[7:3];
  assign eff_speed = coord_t'(SPEED) + ((speed_grp > 5'd2) ? coord_t'(2) : coord_t'(speed_grp));
`else
  assign eff_speed = coord_t'(SPEED);
`endif

  coin_respawn_timer #(.RESPAWN_TICKS(RESPAWN_TICKS)) u_timer (
    .Clk   (Clk),
    .reset (reset),
    .clear (state_q != WAIT),
    .tick  (tick && (state_q == WAIT)),
    .done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (Start) begin
        count_d = '0;
        state_d = SPAWN;
      end
      SPAWN: begin
        x_d     = coord_t'(SCREEN_W);
        y_d     = clamp_y(Rand[8:0]);
        state_d = MOVE;
      end
      // A hit on the same cycle as a tick freezes the coin where it was touched.
      MOVE: begin
        if (hit)                   state_d = COLLECT;
        else if (tick) begin
          if (x_q < eff_speed)     state_d = WAIT;
          else                     x_d     = x_q - eff_speed;
        end
      end
      COLLECT: state_d = WAIT;
      WAIT:    if (tmr_done) state_d = SPAWN;
      default: state_d = IDLE;
    endcase
    if (Ack && (state_q != IDLE)) state_d = IDLE;
    // Only MOVE can lead to COLLECT, so this fires once per coin even with hit held.
    if (state_d == COLLECT && count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= coord_t'(SCREEN_W);
      y_q         <= coord_t'(Y_MIN);
      count_q     <= '0;
      score_inc_q <= 1'b0;
      visible_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      count_q     <= count_d;
      score_inc_q <= (state_d == COLLECT);
      visible_q   <= (state_d == MOVE);
    end
  end

  assign X_Coin_L     = x_q;
  assign X_Coin_R     = x_q + coord_t'(COIN_WIDTH);
  assign Y_Coin       = y_q;
  assign coin_visible = visible_q;
  assign score_inc    = score_inc_q;
  assign coin_count   = count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_coin_sched.sv
// Directed + randomized bench for coin_sched against an arithmetic model of the coin rules.
module tb_coin_sched;

  logic       Clk, reset, Start, Ack, tick, hit;
  logic [9:0] Rand;
  logic [9:0] xl, xr, yc;
  logic       vis, sinc;
  logic [7:0] cnt;
  logic [2:0] st;

  logic       start2, tick2, hit2, ack2;
  logic [9:0] xl2, xr2, yc2;
  logic       vis2, sinc2;
  logic [7:0] cnt2;
  logic [2:0] st2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  localparam int S_IDLE = 0, S_SPAWN = 1, S_MOVE = 2, S_COLLECT = 3, S_WAIT = 4;

  coin_sched dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .tick(tick), .hit(hit), .Rand(Rand),
    .X_Coin_L(xl), .X_Coin_R(xr), .Y_Coin(yc), .coin_visible(vis), .score_inc(sinc),
    .coin_count(cnt), .state(st)
  );

  // Odd spawn position so the coin lands on x=1 and exercises the no-wrap miss.
  coin_sched #(.SCREEN_W(21)) dut_odd (
    .Clk(Clk), .reset(reset), .Start(start2), .Ack(ack2), .tick(tick2), .hit(hit2), .Rand(Rand),
    .X_Coin_L(xl2), .X_Coin_R(xr2), .Y_Coin(yc2), .coin_visible(vis2), .score_inc(sinc2),
    .coin_count(cnt2), .state(st2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (sinc === 1'b1) pulses++;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_spd(input int c);
`ifdef COIN_SCHED_SPEEDUP_EN
    return 2 + (((c / 8) < 2) ? (c / 8) : 2);
`else
    return 2 + 0 * c;
`endif
  endfunction

  function automatic int clamp_ref(input int r);
    int v;
    v = r % 512;
    if (v < 40)  return 40;
    if (v > 400) return 400;
    return v;
  endfunction

  initial begin
    int p0, x, mcnt, sp, r;
    bit missed;
    reset = 1'b0; Start = 1'b0; Ack = 1'b0; tick = 1'b0; hit = 1'b0; Rand = 10'd10;
    start2 = 1'b0; tick2 = 1'b0; hit2 = 1'b0; ack2 = 1'b0;
    repeat (2) cycle();
    chk("rst_state", st, S_IDLE);
    chk("rst_x", xl, 640);
    chk("rst_y", yc, 40);
    chk("rst_cnt", cnt, 0);
    chk("rst_sinc", sinc, 0);
    chk("rst_vis", vis, 0);
    reset = 1'b1;
    cycle();
    chk("idle_hold", st, S_IDLE);

    // Miss from x=1 with speed 2: no wrap, count unchanged, then 60-tick respawn.
    start2 = 1'b1; cycle(); start2 = 1'b0;
    chk("odd_spawn", st2, S_SPAWN);
    cycle();
    chk("odd_move", st2, S_MOVE);
    chk("odd_x0", xl2, 21);
    repeat (10) begin tick2 = 1'b1; cycle(); tick2 = 1'b0; cycle(); end
    chk("odd_x1", xl2, 1);
    tick2 = 1'b1; cycle(); tick2 = 1'b0;
    chk("miss_state", st2, S_WAIT);
    chk("miss_nowrap", xl2, 1);
    chk("miss_cnt", cnt2, 0);
    chk("miss_vis", vis2, 0);
    for (int i = 1; i <= 60; i++) begin
      tick2 = 1'b1; cycle(); tick2 = 1'b0;
      if (i == 59) chk("odd_wait59", st2, S_WAIT);
      if (i == 60) chk("odd_respawn", st2, S_SPAWN);
      else repeat ($urandom_range(0, 2)) cycle();
    end

    // Start, spawn with low Rand, five ticks.
    Rand = 10'd10; Start = 1'b1; cycle(); Start = 1'b0;
    chk("spawn", st, S_SPAWN);
    cycle();
    chk("move", st, S_MOVE);
    chk("y_lo", yc, 40);
    chk("x_spawn", xl, 640);
    chk("vis_move", vis, 1);
    repeat (5) begin tick = 1'b1; cycle(); tick = 1'b0; cycle(); end
    chk("x5", xl, 630);
    chk("xr5", xr, 650);

    // Held hit gives one collect.
    p0 = pulses;
    hit = 1'b1; repeat (10) cycle(); hit = 1'b0;
    chk("hit_pulses", pulses - p0, 1);
    chk("hit_cnt", cnt, 1);
    chk("hit_wait", st, S_WAIT);
    chk("hit_vis", vis, 0);

    Rand = 10'd500;
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1; cycle(); tick = 1'b0;
      if (i == 59) chk("wait59", st, S_WAIT);
      if (i == 60) chk("respawn", st, S_SPAWN);
      else repeat ($urandom_range(0, 2)) cycle();
    end
    cycle();
    chk("y_hi", yc, 400);
    chk("move2", st, S_MOVE);

    // Randomized scroll until missed.
    mcnt = 1; x = 640; missed = 1'b0;
    while (!missed) begin
      Rand = 10'($urandom);
      repeat ($urandom_range(0, 2)) cycle();
      tick = 1'b1; cycle(); tick = 1'b0;
      sp = eff_spd(mcnt);
      if (x < sp) begin
        missed = 1'b1;
        chk("rmiss_state", st, S_WAIT);
      end else begin
        x -= sp;
        chk("rx", xl, x);
        chk("rxr", xr, x + 20);
      end
    end
    chk("rmiss_x", xl, x);
    chk("rmiss_cnt", cnt, mcnt);

    r = int'($urandom_range(0, 1023));
    Rand = 10'(r);
    tick = 1'b1; repeat (60) cycle(); tick = 1'b0;
    chk("rwait_spawn", st, S_SPAWN);
    cycle();
    chk("rclamp", yc, clamp_ref(r));

    // Start outside IDLE ignored; Ack beats hit.
    Start = 1'b1; cycle(); Start = 1'b0;
    chk("start_ign_st", st, S_MOVE);
    chk("start_ign_cnt", cnt, 1);
    p0 = pulses;
    hit = 1'b1; Ack = 1'b1; cycle(); hit = 1'b0; Ack = 1'b0;
    chk("ack_idle", st, S_IDLE);
    chk("ack_sinc", sinc, 0);
    chk("ack_cnt", cnt, 1);
    cycle();
    chk("ack_pulses", pulses - p0, 0);

    // Reset in the middle of WAIT aborts and stays idle.
    Start = 1'b1; cycle(); Start = 1'b0; cycle();
    hit = 1'b1; cycle(); hit = 1'b0; cycle();
    tick = 1'b1; repeat (5) cycle(); tick = 1'b0;
    chk("pre_rst_wait", st, S_WAIT);
    reset = 1'b0; #1;
    chk("arst_state", st, S_IDLE);
    chk("arst_cnt", cnt, 0);
    chk("arst_x", xl, 640);
    cycle();
    reset = 1'b1;
    tick = 1'b1; repeat (70) cycle(); tick = 1'b0;
    chk("post_rst_idle", st, S_IDLE);
    chk("post_rst_vis", vis, 0);

    // Many collects: per-count speed and saturation.
    Start = 1'b1; cycle(); Start = 1'b0; cycle();
    mcnt = 0; p0 = pulses;
    for (int k = 0; k < 257; k++) begin
      tick = 1'b1; cycle(); tick = 1'b0;
      chk("spd", xl, 640 - eff_spd(mcnt));
      hit = 1'b1; cycle(); hit = 1'b0;
      mcnt = (mcnt < 255) ? mcnt + 1 : 255;
      cycle();
      tick = 1'b1; repeat (60) cycle(); tick = 1'b0;
      cycle();
    end
    chk("sat_cnt", cnt, 255);
    chk("sat_pulses", pulses - p0, 257);
    chk("sat_state", st, S_MOVE);
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("sat_spd", xl, 640 - eff_spd(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
